// File: rtl/sram_bus_pkg.sv
// Shared types for the async SRAM bus master: FSM states, turnaround length and
// the registered bus-strobe bundle (also reused by RAM-side models).
package sram_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_SETUP,
        RD_SAMPLE,
        RD_WAIT,
        TURN
    } state_e;

    localparam int TURN_CYCLES = 1;

    typedef struct packed {
        logic cs;
        logic we;
        logic oe;
        logic drive_en;
    } bus_strobe_t;

    localparam bus_strobe_t STROBE_OFF = '0;

endpackage

// File: rtl/sram_bus_master_if.sv
// Request/write/read handshake bundle between a loader and sram_bus_master.
// The master modport is the bus master's view; the slave modport is the loader's.
interface sram_bus_master_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy;

    modport master (
        input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
        output req_ready, wr_ready, rd_valid, rd_data, busy
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
        input  req_ready, wr_ready, rd_valid, rd_data, busy
    );
endinterface

// File: rtl/sram_bus_addr_gen.sv
// Burst address generator: loadable word address wrapping at MEM_DEPTH-1 -> 0,
// plus a beats-remaining down-counter whose zero value marks the last beat.
module sram_bus_addr_gen #(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 4,
    parameter int MEM_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [LEN_WIDTH-1:0]  load_len,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  beats_q, beats_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        addr_d  = addr_q;
        beats_d = beats_q;
        if (load) begin
            addr_d  = load_addr;
            beats_d = load_len;
        end else if (advance) begin
            addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            // Holding at zero keeps a 2^LEN_WIDTH-beat burst from wrapping the counter.
            if (beats_q != '0) beats_d = beats_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            beats_q <= '0;
        end else begin
            addr_q  <= addr_d;
            beats_q <= beats_d;
        end
    end

    assign addr = addr_q;
    assign last = (beats_q == '0);
endmodule

// File: rtl/sram_bus_master.sv
// Async single-port RAM bus master: turns request/beat handshakes into registered,
// glitch-free cs/we/oe sequences and owns the tristate control of mem_data.
module sram_bus_master
    import sram_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_bus_master_if.master     bus,
    output logic [ADDR_WIDTH-1:0] mem_address,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);
    localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    state_e                state_q, state_d;
    bus_strobe_t           strobe_q, strobe_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [TURN_W-1:0]     turn_cnt_q, turn_cnt_d;

    logic                  ag_load, ag_advance, ag_last;
    logic [ADDR_WIDTH-1:0] ag_addr;

    sram_bus_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (ag_load),
        .load_addr (bus.req_addr),
        .load_len  (bus.req_len),
        .advance   (ag_advance),
        .addr      (ag_addr),
        .last      (ag_last)
    );

    // Strobes are decided one state ahead and registered, so each state's
    // decision appears on the pins during the following cycle.
    always_comb begin
        state_d       = state_q;
        strobe_d      = strobe_q;
        mem_address_d = mem_address_q;
        wr_data_d     = wr_data_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = rd_valid_q;
        turn_cnt_d    = turn_cnt_q;
        ag_load       = 1'b0;
        ag_advance    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    ag_load = 1'b1;
                    state_d = bus.req_write ? WR_SETUP : RD_SETUP;
                end
            end
            WR_SETUP: begin
                if (bus.wr_valid) begin
                    mem_address_d = ag_addr;
                    wr_data_d     = bus.wr_data;
                    strobe_d      = '{cs: 1'b1, we: 1'b0, oe: 1'b0, drive_en: 1'b1};
                    state_d       = WR_PULSE;
                end
            end
            WR_PULSE: begin
                strobe_d.we = 1'b1;
                state_d     = WR_HOLD;
            end
            WR_HOLD: begin
                strobe_d.we = 1'b0;
                ag_advance  = 1'b1;
                state_d     = ag_last ? TURN : WR_SETUP;
            end
            RD_SETUP: begin
                mem_address_d = ag_addr;
                strobe_d      = '{cs: 1'b1, we: 1'b0, oe: 1'b1, drive_en: 1'b0};
                state_d       = RD_SAMPLE;
            end
            RD_SAMPLE: begin
                rd_data_d  = mem_data;
                rd_valid_d = 1'b1;
                state_d    = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.rd_ready) begin
                    rd_valid_d = 1'b0;
                    ag_advance = 1'b1;
                    state_d    = ag_last ? TURN : RD_SETUP;
                end
            end
            TURN: begin
                strobe_d = STROBE_OFF;
                if (turn_cnt_q == TURN_W'(TURN_CYCLES - 1)) begin
                    turn_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            strobe_q      <= STROBE_OFF;
            mem_address_q <= '0;
            wr_data_q     <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            turn_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            strobe_q      <= strobe_d;
            mem_address_q <= mem_address_d;
            wr_data_q     <= wr_data_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            turn_cnt_q    <= turn_cnt_d;
        end
    end

    assign mem_data    = strobe_q.drive_en ? wr_data_q : 'z;
    assign mem_address = mem_address_q;
    assign mem_cs      = strobe_q.cs;
    assign mem_we      = strobe_q.we;
    assign mem_oe      = strobe_q.oe;

    assign bus.req_ready = (state_q == IDLE);
    assign bus.wr_ready  = (state_q == WR_SETUP);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_sram_bus_master.sv
// Self-checking bench for sram_bus_master: a behavioural RAM on the bus, a
// transaction-level reference memory, and a per-cycle protocol/data checker.
module tb_sram_bus_master;
    import sram_bus_pkg::*;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int LW = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_bus_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus_if ();

    logic [AW-1:0] mem_address;
    wire  [DW-1:0] mem_data;
    logic          mem_cs, mem_we, mem_oe;

    sram_bus_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if.master),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we),
        .mem_oe      (mem_oe)
    );

    // Observed master tristate enable; the RAM enable comes from the RAM model.
    wire drive_en_obs = dut.strobe_q.drive_en;

    // ---------------- behavioural RAM on the bus ----------------
    logic [DW-1:0] ram [DEPTH];
    logic          ram_loaded = 1'b0;
    bus_strobe_t   ram_strobe;

    always_comb begin
        ram_strobe          = '0;
        ram_strobe.cs       = mem_cs;
        ram_strobe.we       = mem_we;
        ram_strobe.oe       = mem_oe;
        ram_strobe.drive_en = mem_cs && mem_oe && !mem_we;
    end

    assign mem_data = ram_strobe.drive_en ? ram[mem_address[3:0]] : 'z;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 8'(i * 37 + 11);
            ram_loaded <= 1'b1;
        end else if (mem_cs && mem_we) begin
            ram[mem_address[3:0]] <= mem_data;
        end
    end

    // ---------------- reference model and scoreboard ----------------
    logic [DW-1:0] ref_mem [DEPTH];
    logic [15:0]   exp_wr_q[$];
    logic [15:0]   exp_rd_q[$];
    logic [DW-1:0] beat_data [DEPTH];
    logic [DW-1:0] got[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            we_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int wrap_addr(input int a, input int i);
        return (a + i) % DEPTH;
    endfunction

    task automatic push_write(input int addr, input int len);
        for (int i = 0; i <= len; i++) begin
            exp_wr_q.push_back({8'(wrap_addr(addr, i)), beat_data[i]});
            ref_mem[wrap_addr(addr, i)] = beat_data[i];
        end
    endtask

    task automatic push_read(input int addr, input int len);
        for (int i = 0; i <= len; i++)
            exp_rd_q.push_back({8'(wrap_addr(addr, i)), ref_mem[wrap_addr(addr, i)]});
    endtask

    // ---------------- per-cycle compare process ----------------
    logic          have_prev = 1'b0;
    logic          prev_we, prev_cs, prev_drive, prev_oe, prev_rd_valid, prev_rd_ready;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data, prev_rd_data;
    int            cyc = 0, last_drive_cyc = -1, last_oe_cyc = -1, last_cs0_cyc = -1;

    always @(negedge clk) begin
        if (rst) begin
            have_prev = 1'b0;
        end else begin
            cyc++;
            check("no_contention", {31'd0, drive_en_obs && ram_strobe.drive_en}, 0);
            check("ready_vs_busy", {31'd0, bus_if.req_ready}, {31'd0, !bus_if.busy});
            if (bus_if.req_ready)
                check("idle_strobes", {mem_cs, mem_we, mem_oe, drive_en_obs}, 0);
            if (bus_if.wr_ready)
                check("no_we_in_wr_setup", {31'd0, mem_we}, 0);
            if (mem_we) begin
                we_cycles++;
                if (exp_wr_q.size() == 0) check("unexpected_we", 1, 0);
                else check("wr_beat", {mem_address, mem_data}, exp_wr_q.pop_front());
                if (have_prev)
                    check("we_setup", {prev_we, prev_cs, prev_drive, prev_addr, prev_data},
                          {1'b0, 1'b1, 1'b1, mem_address, mem_data});
            end
            if (have_prev && prev_we)
                check("we_hold", {mem_we, mem_cs, drive_en_obs, mem_address, mem_data},
                      {1'b0, 1'b1, 1'b1, prev_addr, prev_data});
            if (have_prev && prev_rd_valid && !prev_rd_ready)
                check("rd_backpressure_hold", {bus_if.rd_valid, bus_if.rd_data, mem_address},
                      {1'b1, prev_rd_data, prev_addr});
            if (bus_if.rd_valid && bus_if.rd_ready) begin
                if (exp_rd_q.size() == 0) check("unexpected_rd_beat", 1, 0);
                else check("rd_beat", {mem_address, bus_if.rd_data}, exp_rd_q.pop_front());
            end
            // A cs-low cycle must separate the last master drive from the next RAM drive and vice versa.
            if (mem_oe && !(have_prev && prev_oe) && last_drive_cyc >= 0)
                check("turn_wr_to_rd", {31'd0, last_cs0_cyc > last_drive_cyc}, 1);
            if (drive_en_obs && !(have_prev && prev_drive) && last_oe_cyc >= 0)
                check("turn_rd_to_wr", {31'd0, last_cs0_cyc > last_oe_cyc}, 1);
            if (drive_en_obs) last_drive_cyc = cyc;
            if (mem_oe)       last_oe_cyc    = cyc;
            if (!mem_cs)      last_cs0_cyc   = cyc;
            have_prev     = 1'b1;
            prev_we       = mem_we;
            prev_cs       = mem_cs;
            prev_oe       = mem_oe;
            prev_drive    = drive_en_obs;
            prev_addr     = mem_address;
            prev_data     = mem_data;
            prev_rd_valid = bus_if.rd_valid;
            prev_rd_ready = bus_if.rd_ready;
            prev_rd_data  = bus_if.rd_data;
        end
    end

    // ---------------- stimulus tasks (entered and left at posedge+1) ----------------
    task automatic issue_req(input logic wr, input int addr, input int len);
        logic ok;
        int   budget;
        bus_if.req_valid = 1'b1;
        bus_if.req_write = wr;
        bus_if.req_addr  = AW'(addr);
        bus_if.req_len   = LW'(len);
        budget = 400;
        do begin
            @(negedge clk) ok = bus_if.req_ready;
            @(posedge clk) #1;
            budget--;
        end while (!ok && budget > 0);
        if (!ok) check("req_accept_timeout", 1, 0);
        bus_if.req_valid = 1'b0;
    endtask

    task automatic feed_writes(input int len, input int stall_beat, input int stall_cyc, input bit rand_gap);
        logic ok;
        int   budget, gap;
        for (int i = 0; i <= len; i++) begin
            gap = (i == stall_beat) ? stall_cyc : (rand_gap ? int'($urandom_range(0, 2)) : 0);
            repeat (gap) @(posedge clk) #1;
            bus_if.wr_valid = 1'b1;
            bus_if.wr_data  = beat_data[i];
            budget = 200;
            do begin
                @(negedge clk) ok = bus_if.wr_ready;
                @(posedge clk) #1;
                budget--;
            end while (!ok && budget > 0);
            if (!ok) check("wr_accept_timeout", 1, 0);
            bus_if.wr_valid = 1'b0;
        end
    endtask

    task automatic drain_reads(input int len, input int stall_beat, input int stall_cyc, input bit rand_stall);
        int budget, gap;
        for (int i = 0; i <= len; i++) begin
            budget = 200;
            while (!bus_if.rd_valid && budget > 0) begin
                @(posedge clk) #1;
                budget--;
            end
            if (!bus_if.rd_valid) begin
                check("rd_valid_timeout", 1, 0);
                return;
            end
            gap = (i == stall_beat) ? stall_cyc : (rand_stall ? int'($urandom_range(0, 2)) : 0);
            repeat (gap) @(posedge clk) #1;
            got.push_back(bus_if.rd_data);
            bus_if.rd_ready = 1'b1;
            @(posedge clk) #1;
            bus_if.rd_ready = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int budget = 200;
        while (bus_if.busy && budget > 0) begin
            @(posedge clk) #1;
            budget--;
        end
        check("idle_reached", {31'd0, bus_if.busy}, 0);
        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("rd_queue_drained", exp_rd_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobes"}, {mem_cs, mem_we, mem_oe, drive_en_obs}, 0);
        check({tag, "_address"}, mem_address, 0);
        check({tag, "_handshake"}, {bus_if.req_ready, bus_if.wr_ready, bus_if.rd_valid, bus_if.busy}, 4'b1000);
        check({tag, "_rd_data"}, bus_if.rd_data, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int we0, budget;
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_len   = '0;
        bus_if.wr_valid  = 1'b0;
        bus_if.wr_data   = '0;
        bus_if.rd_ready  = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i * 37 + 11);

        // Reset values while held in reset.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single write: addr 3, one beat of A5, exactly one we cycle.
        beat_data[0] = 8'hA5;
        we0 = we_cycles;
        push_write(3, 0);
        issue_req(1'b1, 3, 0);
        feed_writes(0, -1, 0, 1'b0);
        wait_idle();
        check("single_we_cycles", we_cycles - we0, 1);
        check("single_ram3", ram[3], 8'hA5);

        // Wrap burst 14..1 then read back.
        for (int i = 0; i < 4; i++) beat_data[i] = 8'(i + 1);
        push_write(14, 3);
        issue_req(1'b1, 14, 3);
        feed_writes(3, -1, 0, 1'b0);
        wait_idle();
        check("wrap_ram", {ram[14], ram[15], ram[0], ram[1]}, 32'h01020304);
        got.delete();
        push_read(14, 3);
        issue_req(1'b0, 14, 3);
        drain_reads(3, -1, 0, 1'b0);
        wait_idle();
        check("wrap_readback", {got[0], got[1], got[2], got[3]}, 32'h01020304);

        // Backpressure: rd_ready low 3 cycles on beat 2.
        got.delete();
        push_read(14, 3);
        issue_req(1'b0, 14, 3);
        drain_reads(3, 1, 3, 1'b0);
        wait_idle();
        check("bp_beats", got.size(), 4);
        check("bp_readback", {got[0], got[1], got[2], got[3]}, 32'h01020304);

        // Write stalled 5 cycles in WR_SETUP while a read request is already held.
        beat_data[0] = 8'h11; beat_data[1] = 8'h22; beat_data[2] = 8'h33;
        we0 = we_cycles;
        push_write(8, 2);
        issue_req(1'b1, 8, 2);
        push_read(8, 2);
        got.delete();
        fork
            feed_writes(2, 0, 5, 1'b0);
            begin
                issue_req(1'b0, 8, 2);
                check("req2_after_writes", we_cycles - we0, 3);
            end
        join
        drain_reads(2, -1, 0, 1'b0);
        wait_idle();
        check("turn_readback", {8'h00, got[0], got[1], got[2]}, 32'h00112233);

        // Full-length burst of 2^LEN_WIDTH beats across the wrap.
        for (int i = 0; i < DEPTH; i++) beat_data[i] = 8'($urandom);
        we0 = we_cycles;
        push_write(5, 15);
        issue_req(1'b1, 5, 15);
        feed_writes(15, -1, 0, 1'b1);
        wait_idle();
        check("max_len_we_cycles", we_cycles - we0, 16);

        // Reset in the middle of a write pulse.
        beat_data[0] = 8'h3C;
        issue_req(1'b1, 5, 0);
        bus_if.wr_valid = 1'b1;
        bus_if.wr_data  = 8'h3C;
        budget = 20;
        while (!mem_we && budget > 0) begin
            @(posedge clk) #1;
            budget--;
        end
        check("reached_we_pulse", {31'd0, mem_we}, 1);
        bus_if.wr_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midburst_reset");
        @(posedge clk) #1;
        rst = 1'b0;
        exp_wr_q.delete();
        exp_rd_q.delete();
        ref_mem[5] = ram[5];
        check("no_rd_valid_after_reset", {31'd0, bus_if.rd_valid}, 0);

        // Randomized bursts.
        for (int n = 0; n < 40; n++) begin
            int a, l;
            a = int'($urandom_range(0, DEPTH - 1));
            l = int'($urandom_range(0, (1 << LW) - 1));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= l; i++) beat_data[i] = 8'($urandom);
                push_write(a, l);
                issue_req(1'b1, a, l);
                feed_writes(l, -1, 0, 1'b1);
            end else begin
                push_read(a, l);
                issue_req(1'b0, a, l);
                drain_reads(l, -1, 0, 1'b1);
            end
            wait_idle();
        end

        @(posedge clk) #1;
        for (int i = 0; i < DEPTH; i++) check("final_ram", ram[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
